// File: rtl/ir_sample_seq.sv
// ir_sample_seq: sweeps three IR emitter pairs through the A2D and reports a weighted right-minus-left line error.
module ir_sample_seq #(
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  output logic               strt_cnv,
  output logic [2:0]         chnnl,
  input  logic               cnv_cmplt,
  input  logic [11:0]        A2D_res,
  output logic               IR_in_en,
  output logic               IR_mid_en,
  output logic               IR_out_en,
  output logic signed [15:0] error,
  output logic               err_vld,
  output logic               busy
);
  localparam int CW = $clog2(SETTLE_CYCLES);
  typedef enum logic [2:0] {IDLE, SETTLE, CNV_R, WAIT_R, CNV_L, WAIT_L, ACCUM, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [11:0] right;
  logic signed [15:0] acc;
  logic [2:0] en;
  logic [2:0] r_ch, l_ch;
  logic signed [12:0] diff;
  logic signed [15:0] diff_ext;
  assign {IR_out_en, IR_mid_en, IR_in_en} = en;
  assign r_ch = idx == 2'd0 ? 3'd1 : idx == 2'd1 ? 3'd4 : 3'd3;
  assign l_ch = idx == 2'd0 ? 3'd0 : idx == 2'd1 ? 3'd2 : 3'd7;
  assign diff = $signed({1'b0, right}) - $signed({1'b0, A2D_res});
  assign diff_ext = {{3{diff[12]}}, diff};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      strt_cnv <= 1'b0;
      chnnl <= '0;
      en <= '0;
      error <= '0;
      err_vld <= 1'b0;
      busy <= 1'b0;
      acc <= '0;
      right <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      strt_cnv <= 1'b0;
      err_vld <= 1'b0;
      case (state)
        IDLE: if (go) begin
          acc <= '0;
          idx <= '0;
          cnt <= '0;
          busy <= 1'b1;
          en <= 3'b001;
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            strt_cnv <= 1'b1;
            chnnl <= r_ch;
            state <= CNV_R;
          end
        end
        CNV_R: state <= WAIT_R;
        WAIT_R: if (cnv_cmplt) begin
          right <= A2D_res;
          strt_cnv <= 1'b1;
          chnnl <= l_ch;
          state <= CNV_L;
        end
        CNV_L: state <= WAIT_L;
        WAIT_L: if (cnv_cmplt) begin
          acc <= acc + (diff_ext <<< idx);
          state <= ACCUM;
        end
        ACCUM: if (idx == 2'd2) begin
          error <= acc;
          err_vld <= 1'b1;
          en <= '0;
          state <= DONE;
        end else begin
          idx <= idx + 2'd1;
          cnt <= '0;
          en <= en << 1;
          state <= SETTLE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ir_sample_seq.md
Name: ir_sample_seq

Overview:
- Sequencer between the digital core and the A2D interface for line sensing.
- Per sweep, for each of three IR sensor pairs (inner, mid, outer):
  - Enables that pair's IR emitters and waits for them to settle.
  - Requests a conversion on the right sensor, then on the left sensor, via the A2D interface's strt_cnv/cnv_cmplt handshake.
  - Accumulates a weighted right-minus-left difference.
- The signed line-position error is handed to the core's steering logic with a one-cycle valid strobe.

Parameters:
SETTLE_CYCLES, 4096, clocks an emitter pair is enabled before its first conversion request (must be >= 2)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, synchronous, active low
go  in  1  start a sweep; sampled only in IDLE
strt_cnv  out  1  one-cycle conversion request to the A2D interface
chnnl  out  3  A2D channel to convert
cnv_cmplt  in  1  conversion done (level or pulse from the A2D interface)
A2D_res  in  12  unsigned conversion result; valid when cnv_cmplt is high
IR_in_en  out  1  inner emitter pair enable
IR_mid_en  out  1  mid emitter pair enable
IR_out_en  out  1  outer emitter pair enable
error  out  16  signed weighted error; positive = line to the right
err_vld  out  1  one-cycle strobe; error updated this cycle
busy  out  1  high from the cycle after go is accepted until the cycle after err_vld

Behaviour:
- Reset: all of the following clear on the first rising edge with rst_n low, regardless of state:
  - Outputs strt_cnv, chnnl, IR_*_en, error, err_vld and busy go to 0.
  - Internal accumulator, right-sample register, pair index and settle counter go to 0.
  - State goes to IDLE.
- Pair table (index: weight, right channel, left channel, enable):
  - 0: x1, right ch 1, left ch 0, IR_in_en.
  - 1: x2, right ch 4, left ch 2, IR_mid_en.
  - 2: x4, right ch 3, left ch 7, IR_out_en.
- States: IDLE, SETTLE, CNV_R, WAIT_R, CNV_L, WAIT_L, ACCUM, DONE.
- IDLE:
  - If go: clear the accumulator, set pair index to 0, clear the settle counter, go to SETTLE, set busy.
  - If not go: stay in IDLE.
- SETTLE:
  - Only the current pair's enable is high; the other enables are low.
  - The counter increments each cycle; at SETTLE_CYCLES-1, go to CNV_R.
- CNV_R:
  - strt_cnv=1 for exactly this cycle; chnnl = right channel; go to WAIT_R.
- WAIT_R:
  - chnnl is held.
  - When cnv_cmplt=1, latch A2D_res into the right-sample register and go to CNV_L.
- CNV_L:
  - strt_cnv=1 for one cycle; chnnl = left channel; go to WAIT_L.
- WAIT_L:
  - When cnv_cmplt=1, compute diff = {1'b0,right} - {1'b0,A2D_res} as 13-bit signed.
  - Add sign-extended diff << (pair index) to the 16-bit signed accumulator; go to ACCUM.
- ACCUM:
  - If pair index == 2, go to DONE.
  - Otherwise increment the pair index, clear the counter and go to SETTLE.
- DONE:
  - error <= accumulator; err_vld = 1 for this single cycle; all enables low.
  - Go to IDLE; busy drops on entry to IDLE.
- The emitter enable for the current pair stays high through SETTLE, the conversions and ACCUM of that pair. Enables are one-hot or all-zero at all times.
- Arithmetic range: max |sum| = 7*4095 = 28665, so the 16-bit accumulator cannot overflow; no saturation is needed.
- go while busy is ignored; there is no queueing.
- cnv_cmplt outside WAIT_R/WAIT_L is ignored.
- cnv_cmplt in the same cycle as strt_cnv (in CNV_R/CNV_L) is ignored; only WAIT states sample it.
- No timeout: the block waits indefinitely for cnv_cmplt.
- error holds its value between sweeps; it changes only in DONE.
- Sweep latency from go accepted, with a fixed A2D latency of L cycles (cnv_cmplt L cycles after strt_cnv):
  - 3*(SETTLE_CYCLES + 2*(L+1) + 1) + 1 cycles to the err_vld cycle.
- go may be asserted in the same cycle busy falls (IDLE); it starts a new sweep immediately.

Test Plan:
- A2D model returns 0x800 on every channel, L=20, SETTLE_CYCLES=8:
  - go pulse -> err_vld once, error = 0.
  - Channel order observed on strt_cnv is 1,0,4,2,3,7.
  - err_vld occurs 3*(8+42+1)+1 = 154 cycles after go.
- Ch1=0x900, all others 0x800 -> error = +256 (0x0100).
- Ch7=0xFFF, ch3=0x000, others equal -> error = -16380 (0xC004).
- Right channels = 0xFFF, left channels = 0x000 -> error = +28665 (0x6FF9); reversed gives -28665 (0x9007).
- Enable sequencing:
  - IR_in_en high from the cycle after go until ch0 completes; then IR_mid_en, then IR_out_en.
  - Never two enables high at once.
  - go re-pulsed mid-sweep has no effect: one err_vld, same error.
- Reset mid-sweep:
  - rst_n low for 1 cycle during WAIT_L of pair 1 -> next cycle all outputs 0, IDLE.
  - A late cnv_cmplt is then ignored.
  - A following go yields a correct full sweep.
